hazard3_instr_compress_packer: RTL and testbench
================================================

Name: hazard3_instr_compress_packer

Overview:
Streaming RVC encoder, the inverse of the core's decompression path. Accepts a stream of 32-bit RV32I instructions and re-encodes each compressible one into its canonical 16-bit form. Packs the resulting mixed 16/32-bit stream little-endian into 32-bit output words. Used by the debug program-buffer loader and the test-image generator to produce compact images that the frontend decompresses back to the original instructions.

Parameters:
ENABLE_C, 1, when 0 every instruction is emitted uncompressed and the packer never enters HALF or FLUSH.
W_CNT, 16, width of the saturating compressed-instruction counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input instruction valid
in_ready  output  1  input accepted when in_valid && in_ready
in_instr  input  32  32-bit instruction
in_last  input  1  last instruction of image; forces flush/pad
out_valid  output  1  output word valid (registered)
out_ready  input  1  sink accepts word when out_valid && out_ready
out_data  output  32  packed word; first halfword in [15:0]
out_last  output  1  final word of image
err  output  1  sticky: an input had in_instr[1:0] != 2'b11
cnt_compressed  output  W_CNT  saturating count of instructions emitted as 16-bit

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: out_valid=0, out_data=0, out_last=0, err=0, cnt_compressed=0, state=EMPTY. A pending halfword is discarded.
- Reset mid-image: the partial word is dropped with no output.
- Output register: out_data, out_valid and out_last are held stable while out_valid && !out_ready.
- Slot free (slot_free) = !out_valid || out_ready.
- in_ready = slot_free && state != FLUSH.
- Compression is combinational on in_instr. First matching rule applies; otherwise the instruction stays 32-bit.
  - addi rd,x0,imm with rd!=0, imm in [-32,31] -> c.li
  - addi rd,rd,imm with rd!=0, imm!=0, imm in [-32,31] -> c.addi
  - add rd,x0,rs2 with rd!=0, rs2!=0 -> c.mv
  - add rd,rd,rs2 with rd!=0, rs2!=0 -> c.add
  - lw rd,off(x2) with rd!=0, off%4==0, 0<=off<=252 -> c.lwsp
  - sw rs2,off(x2) with off%4==0, 0<=off<=252 -> c.swsp
  - lw/sw with registers in x8..x15, off%4==0, 0<=off<=124 -> c.lw/c.sw
  - sub/xor/or/and rd,rd,rs2 with rd and rs2 in x8..x15 -> c.sub/c.xor/c.or/c.and
  - ebreak -> c.ebreak
  - Branches, jumps, lui, auipc, system and other ops are never compressed.
- Input with [1:0] != 2'b11: passed through as 32-bit, err set (sticky until reset).
- FSM. h = 16-bit pending register. c = compressed halfword, i = 32-bit instruction, pad = 16'h0001 (c.nop).
  - EMPTY + c, !last: h<=c, go to HALF, no output.
  - EMPTY + c, last: emit {pad,c} with last.
  - EMPTY + i: emit i, out_last=in_last, stay in EMPTY.
  - HALF + c: emit {c,h}, out_last=in_last, go to EMPTY.
  - HALF + i, !last: emit {i[15:0],h}, h<=i[31:16], stay in HALF.
  - HALF + i, last: emit {i[15:0],h} (not last), h<=i[31:16], go to FLUSH.
  - FLUSH: in_ready=0. When slot_free: emit {pad,h} with last, go to EMPTY.
- Emitting a word sets out_valid=1. If the slot is freed with no new emission, out_valid<=0.
- cnt_compressed increments on each accepted compressible instruction and saturates at all-ones.
- Latency: an accepted word appears on the cycle after the handshake. Throughput is one instruction per cycle with out_ready held high; FLUSH adds exactly one cycle.

Test Plan:
- 0x00140413 (addi x8,x8,1), then 0x00B00533 (mv a0,a1) with last -> single word 0x852E0405 with out_last=1; cnt_compressed=2.
- 0x00140413, then 0x123452B7 (lui x5,0x12345) with last -> 0x52B70405 (not last), then 0x00011234 with last. in_ready is low for exactly one cycle (FLUSH).
- 0x02040413 (addi imm=32, out of range) with last -> 0x02040413 last; cnt_compressed unchanged.
- 0x00412483 (lw x9,4(x2)) with last -> 0x00014492 last (c.lwsp padded with c.nop).
- out_ready held low for 5 cycles with a word pending -> out_data stable, in_ready=0, no input lost. Then 0x00000013 (nop -> c.li x0 disallowed) emits 0x00000013.
- Input 0x00000001 -> passthrough word, err=1. Assert rst while in HALF -> all outputs zero next cycle, no partial word emitted.

Source files
------------

// File: rtl/hazard3_instr_compress_packer.sv
// Streaming RV32I -> RVC re-encoder that packs the mixed 16/32-bit stream
// little-endian into 32-bit words, padding odd image tails with c.nop.
module hazard3_instr_compress_packer #(
  parameter int unsigned ENABLE_C = 1,
  parameter int unsigned W_CNT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             err,
  output logic [W_CNT-1:0] cnt_compressed
);

  localparam logic [15:0] PAD = 16'h0001;

  typedef enum logic [1:0] {ST_EMPTY, ST_HALF, ST_FLUSH} state_t;

  state_t      state, state_nxt;
  logic [15:0] pend_h_p0;

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + {{(W_CNT-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic is_rvc_reg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

  logic [6:0]         opc, f7;
  logic [2:0]         f3;
  logic [4:0]         rd, rs1, rs2;
  logic signed [11:0] imm_i;
  logic [11:0]        lw_off, sw_off;
  logic               is_addi, is_add, is_lw, is_sw, imm_small;

  assign opc    = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign imm_i  = in_instr[31:20];
  assign lw_off = in_instr[31:20];
  assign sw_off = {in_instr[31:25], in_instr[11:7]};

  assign is_addi   = (opc == 7'h13) && (f3 == 3'b000);
  assign is_add    = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h00);
  assign is_lw     = (opc == 7'h03) && (f3 == 3'b010);
  assign is_sw     = (opc == 7'h23) && (f3 == 3'b010);
  assign imm_small = (imm_i >= -12'sd32) && (imm_i <= 12'sd31);

  logic       alu_ok;
  logic [1:0] alu_sel;

  always_comb begin
    alu_ok  = 1'b0;
    alu_sel = 2'b00;
    if (opc == 7'h33) begin
      if (f7 == 7'h20 && f3 == 3'b000) begin
        alu_ok  = 1'b1;
        alu_sel = 2'b00;
      end else if (f7 == 7'h00) begin
        case (f3)
          3'b100:  begin alu_ok = 1'b1; alu_sel = 2'b01; end
          3'b110:  begin alu_ok = 1'b1; alu_sel = 2'b10; end
          3'b111:  begin alu_ok = 1'b1; alu_sel = 2'b11; end
          default: alu_ok = 1'b0;
        endcase
      end
    end
  end

  // Compression: first matching rule wins
  logic        c_ok, is_c;
  logic [15:0] c_half;

  always_comb begin
    c_ok   = 1'b0;
    c_half = 16'h0000;
    if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
      c_ok   = 1'b1;
      c_half = {3'b010, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (is_addi && rs1 == rd && rd != 5'd0 && imm_i != 12'sd0 && imm_small) begin
      c_ok   = 1'b1;
      c_half = {3'b000, in_instr[25], rd, in_instr[24:20], 2'b01};
    end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
      c_ok   = 1'b1;
      c_half = {4'b1000, rd, rs2, 2'b10};
    end else if (is_add && rs1 == rd && rd != 5'd0 && rs2 != 5'd0) begin
      c_ok   = 1'b1;
      c_half = {4'b1001, rd, rs2, 2'b10};
    end else if (is_lw && rs1 == 5'd2 && rd != 5'd0 && lw_off[11:8] == 4'h0 && lw_off[1:0] == 2'b00) begin
      c_ok   = 1'b1;
      c_half = {3'b010, lw_off[5], rd, lw_off[4:2], lw_off[7:6], 2'b10};
    end else if (is_sw && rs1 == 5'd2 && sw_off[11:8] == 4'h0 && sw_off[1:0] == 2'b00) begin
      c_ok   = 1'b1;
      c_half = {3'b110, sw_off[5:2], sw_off[7:6], rs2, 2'b10};
    end else if (is_lw && is_rvc_reg(rs1) && is_rvc_reg(rd) && lw_off[11:7] == 5'd0 && lw_off[1:0] == 2'b00) begin
      c_ok   = 1'b1;
      c_half = {3'b010, lw_off[5:3], rs1[2:0], lw_off[2], lw_off[6], rd[2:0], 2'b00};
    end else if (is_sw && is_rvc_reg(rs1) && is_rvc_reg(rs2) && sw_off[11:7] == 5'd0 && sw_off[1:0] == 2'b00) begin
      c_ok   = 1'b1;
      c_half = {3'b110, sw_off[5:3], rs1[2:0], sw_off[2], sw_off[6], rs2[2:0], 2'b00};
    end else if (alu_ok && rs1 == rd && is_rvc_reg(rd) && is_rvc_reg(rs2)) begin
      c_ok   = 1'b1;
      c_half = {6'b100011, rd[2:0], alu_sel, rs2[2:0], 2'b01};
    end else if (in_instr == 32'h0010_0073) begin
      c_ok   = 1'b1;
      c_half = 16'h9002;
    end
  end

  assign is_c = (ENABLE_C != 0) && c_ok;

  logic slot_free, accept;
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != ST_FLUSH);
  assign accept    = in_valid && in_ready;

  // Packing FSM: decides the word to emit and the next pending halfword
  logic        emit, emit_last, h_we;
  logic [31:0] emit_data;
  logic [15:0] h_nxt;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_data = in_instr;
    emit_last = in_last;
    h_we      = 1'b0;
    h_nxt     = in_instr[31:16];
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          if (is_c && in_last) begin
            emit      = 1'b1;
            emit_data = {PAD, c_half};
            emit_last = 1'b1;
          end else if (is_c) begin
            h_we      = 1'b1;
            h_nxt     = c_half;
            state_nxt = ST_HALF;
          end else begin
            emit = 1'b1;
          end
        end
      end
      ST_HALF: begin
        if (accept) begin
          emit = 1'b1;
          if (is_c) begin
            emit_data = {c_half, pend_h_p0};
            state_nxt = ST_EMPTY;
          end else begin
            emit_data = {in_instr[15:0], pend_h_p0};
            emit_last = 1'b0;
            h_we      = 1'b1;
            state_nxt = in_last ? ST_FLUSH : ST_HALF;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_data = {PAD, pend_h_p0};
          emit_last = 1'b1;
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_EMPTY;
      out_valid      <= 1'b0;
      out_data       <= 32'h0;
      out_last       <= 1'b0;
      err            <= 1'b0;
      cnt_compressed <= '0;
    end else begin
      state <= state_nxt;
      if (slot_free) begin
        out_valid <= emit;
        if (emit) begin
          out_data <= emit_data;
          out_last <= emit_last;
        end
      end
      if (accept && in_instr[1:0] != 2'b11) err <= 1'b1;
      if (accept && is_c) cnt_compressed <= sat_inc(cnt_compressed);
    end
  end

  always_ff @(posedge clk) begin
    if (h_we) pend_h_p0 <= h_nxt;
  end

endmodule

// File: tb/tb_hazard3_instr_compress_packer.sv
// Bench for the RVC packer: directed image cases plus a randomized stream
// checked against a halfword-queue model of the encoder and packer.
`timescale 1ns/1ps
module tb_hazard3_instr_compress_packer;

  localparam int W_CNT = 6;
  localparam int CMAX  = (1 << W_CNT) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = 32'h0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic             out_last;
  logic             err;
  logic [W_CNT-1:0] cnt_compressed;

  always #5 clk = ~clk;

  hazard3_instr_compress_packer #(.ENABLE_C(1), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .cnt_compressed(cnt_compressed)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoder: field arithmetic straight from the compression rules
  function automatic bit rvc_r(input int r);
    return r >= 8 && r <= 15;
  endfunction

  function automatic int ref_c(input logic [31:0] x);
    int op, rd, f3, rs1, rs2, f7, ii, si, k;
    op = int'(x[6:0]);   rd  = int'(x[11:7]);  f3 = int'(x[14:12]);
    rs1 = int'(x[19:15]); rs2 = int'(x[24:20]); f7 = int'(x[31:25]);
    ii = int'($signed(x[31:20]));
    si = int'($signed({x[31:25], x[11:7]}));
    if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && ii >= -32 && ii <= 31)
      return (2 << 13) | (((ii >> 5) & 1) << 12) | (rd << 7) | ((ii & 31) << 2) | 1;
    if (op == 19 && f3 == 0 && rs1 == rd && rd != 0 && ii != 0 && ii >= -32 && ii <= 31)
      return (((ii >> 5) & 1) << 12) | (rd << 7) | ((ii & 31) << 2) | 1;
    if (op == 51 && f3 == 0 && f7 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
      return (8 << 12) | (rd << 7) | (rs2 << 2) | 2;
    if (op == 51 && f3 == 0 && f7 == 0 && rs1 == rd && rd != 0 && rs2 != 0)
      return (9 << 12) | (rd << 7) | (rs2 << 2) | 2;
    if (op == 3 && f3 == 2 && rs1 == 2 && rd != 0 && ii % 4 == 0 && ii >= 0 && ii <= 252)
      return (2 << 13) | (((ii >> 5) & 1) << 12) | (rd << 7) | (((ii >> 2) & 7) << 4) | (((ii >> 6) & 3) << 2) | 2;
    if (op == 35 && f3 == 2 && rs1 == 2 && si % 4 == 0 && si >= 0 && si <= 252)
      return (6 << 13) | (((si >> 2) & 15) << 9) | (((si >> 6) & 3) << 7) | (rs2 << 2) | 2;
    if (op == 3 && f3 == 2 && rvc_r(rs1) && rvc_r(rd) && ii % 4 == 0 && ii >= 0 && ii <= 124)
      return (2 << 13) | (((ii >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((ii >> 2) & 1) << 6) | (((ii >> 6) & 1) << 5) | ((rd - 8) << 2);
    if (op == 35 && f3 == 2 && rvc_r(rs1) && rvc_r(rs2) && si % 4 == 0 && si >= 0 && si <= 124)
      return (6 << 13) | (((si >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((si >> 2) & 1) << 6) | (((si >> 6) & 1) << 5) | ((rs2 - 8) << 2);
    if (op == 51 && rs1 == rd && rvc_r(rd) && rvc_r(rs2)) begin
      k = (f7 == 32 && f3 == 0) ? 0 : (f7 == 0 && f3 == 4) ? 1 :
          (f7 == 0 && f3 == 6) ? 2 : (f7 == 0 && f3 == 7) ? 3 : -1;
      if (k >= 0) return (35 << 10) | ((rd - 8) << 7) | (k << 5) | ((rs2 - 8) << 2) | 1;
    end
    if (x == 32'h0010_0073) return 32'h9002;
    return -1;
  endfunction

  // Monitor-owned model state and observation log
  logic [15:0] hq[$];
  logic [31:0] exp_d[$];
  bit          exp_l[$];
  logic [31:0] obs_d[$];
  bit          obs_l[$];
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  int          irdy_low = 0;

  task automatic model_push(input logic [31:0] x, input bit l);
    int c;
    c = ref_c(x);
    if (x[1:0] != 2'b11) m_err = 1'b1;
    if (c >= 0) begin
      hq.push_back(16'(c));
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      hq.push_back(x[15:0]);
      hq.push_back(x[31:16]);
    end
    while (hq.size() >= 2) begin
      exp_d.push_back({hq[1], hq[0]});
      hq.pop_front();
      hq.pop_front();
      exp_l.push_back(l && hq.size() == 0);
    end
    if (l && hq.size() == 1) begin
      exp_d.push_back({16'h0001, hq[0]});
      exp_l.push_back(1'b1);
      hq.pop_front();
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hq.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (!in_ready) irdy_low++;
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data);
        obs_l.push_back(out_last);
      end
      if (in_valid && in_ready) model_push(in_instr, in_last);
    end
  end

  // Main-thread stimulus
  bit rdy_rand = 1'b0;
  int cmp_idx  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] x, input bit l);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = x;
    in_last  = l;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check_eq("send_accept", 32'(done), 32'd1);
  endtask

  task automatic compare_stream();
    while (cmp_idx < obs_d.size() && cmp_idx < exp_d.size()) begin
      check_eq("word_data", obs_d[cmp_idx], exp_d[cmp_idx]);
      check_eq("word_last", 32'(obs_l[cmp_idx]), 32'(exp_l[cmp_idx]));
      cmp_idx++;
    end
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    while (!done && n < 100) begin
      done = !out_valid && obs_d.size() >= exp_d.size();
      if (!done) tick();
      n++;
    end
    check_eq("drain_done", 32'(done), 32'd1);
    compare_stream();
    check_eq("word_count", 32'(obs_d.size()), 32'(exp_d.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd2;
      2:       return 5'(8 + $urandom_range(0, 7));
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [11:0] pick_imm();
    case ($urandom_range(0, 2))
      0:       return 12'(int'($urandom_range(0, 80)) - 40);
      1:       return 12'(4 * $urandom_range(0, 66));
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs1x, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    rd = pick_reg(); rs1 = pick_reg(); rs2 = pick_reg(); imm = pick_imm();
    case ($urandom_range(0, 2))
      0:       rs1x = 5'd0;
      1:       rs1x = rd;
      default: rs1x = rs1;
    endcase
    case ($urandom_range(0, 5))
      0:       begin f7 = 7'h00; f3 = 3'b000; end
      1:       begin f7 = 7'h20; f3 = 3'b000; end
      2:       begin f7 = 7'h00; f3 = 3'b100; end
      3:       begin f7 = 7'h00; f3 = 3'b110; end
      4:       begin f7 = 7'h00; f3 = 3'b111; end
      default: begin f7 = 7'h00; f3 = 3'($urandom_range(1, 3)); end
    endcase
    case ($urandom_range(0, 12))
      0, 1:    return {imm, rs1x, 3'b000, rd, 7'h13};
      2, 3:    return {f7, rs2, rs1x, f3, rd, 7'h33};
      4, 5:    return {imm, rs1, 3'b010, rd, 7'h03};
      6, 7:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      8:       return {20'($urandom), rd, 7'h37};
      9:       return {25'($urandom), 7'h63};
      10:      return 32'h0000_0073;
      11:      return 32'h0010_0073;
      default: return 32'($urandom);
    endcase
  endfunction

  int n0, lo0;

  initial begin
    tick();
    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_cnt", 32'(cnt_compressed), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // c.addi + c.mv packed into one word
    n0 = obs_d.size();
    send(32'h0014_0413, 1'b0);
    send(32'h00B0_0533, 1'b1);
    drain();
    check_eq("t1_nwords", 32'(obs_d.size() - n0), 32'd1);
    check_eq("t1_word", obs_d[obs_d.size()-1], 32'h852E_0405);
    check_eq("t1_last", 32'(obs_l[obs_l.size()-1]), 32'd1);
    check_eq("t1_cnt", 32'(cnt_compressed), 32'd2);

    // Straddling 32-bit instruction then flush
    do_reset();
    n0 = obs_d.size();
    lo0 = irdy_low;
    send(32'h0014_0413, 1'b0);
    send(32'h1234_52B7, 1'b1);
    drain();
    check_eq("t2_nwords", 32'(obs_d.size() - n0), 32'd2);
    check_eq("t2_word0", obs_d[n0], 32'h52B7_0405);
    check_eq("t2_last0", 32'(obs_l[n0]), 32'd0);
    check_eq("t2_word1", obs_d[n0+1], 32'h0001_1234);
    check_eq("t2_last1", 32'(obs_l[n0+1]), 32'd1);
    check_eq("t2_flush_cycles", 32'(irdy_low - lo0), 32'd1);

    // Immediate out of range stays 32-bit
    do_reset();
    send(32'h0204_0413, 1'b1);
    drain();
    check_eq("t3_word", obs_d[obs_d.size()-1], 32'h0204_0413);
    check_eq("t3_last", 32'(obs_l[obs_l.size()-1]), 32'd1);
    check_eq("t3_cnt", 32'(cnt_compressed), 32'd0);

    // c.lwsp padded with c.nop
    do_reset();
    send(32'h0041_2483, 1'b1);
    drain();
    check_eq("t4_word", obs_d[obs_d.size()-1], 32'h0001_4492);
    check_eq("t4_last", 32'(obs_l[obs_l.size()-1]), 32'd1);

    // Backpressure: output held, input stalled but not lost
    do_reset();
    n0 = obs_d.size();
    out_ready = 1'b0;
    send(32'h0000_0013, 1'b1);
    in_valid = 1'b1;
    in_instr = 32'h0010_0073;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_hold_data", out_data, 32'h0000_0013);
      check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t5_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(32'h0010_0073, 1'b1);
    drain();
    check_eq("t5_nwords", 32'(obs_d.size() - n0), 32'd2);
    check_eq("t5_word0", obs_d[n0], 32'h0000_0013);
    check_eq("t5_word1", obs_d[n0+1], 32'h0001_9002);

    // Illegal low bits set err; reset in HALF drops the partial word
    do_reset();
    send(32'h0000_0001, 1'b0);
    drain();
    check_eq("t6_word", obs_d[obs_d.size()-1], 32'h0000_0001);
    check_eq("t6_err", 32'(err), 32'd1);
    send(32'h0014_0413, 1'b0);
    drain();
    n0 = obs_d.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_data", out_data, 32'h0);
    check_eq("t6_rst_last", 32'(out_last), 32'd0);
    check_eq("t6_rst_err", 32'(err), 32'd0);
    check_eq("t6_rst_cnt", 32'(cnt_compressed), 32'd0);
    repeat (3) tick();
    check_eq("t6_no_partial", 32'(obs_d.size() - n0), 32'd0);

    // Randomized stream with random backpressure
    do_reset();
    rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      send(rand_instr(), $urandom_range(0, 5) == 0);
      compare_stream();
      check_eq("rnd_cnt", 32'(cnt_compressed), 32'(m_cnt));
      check_eq("rnd_err", 32'(err), 32'(m_err));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rdy_rand = 1'b1;
    send(32'h0014_0413, 1'b1);
    drain();
    check_eq("end_cnt", 32'(cnt_compressed), 32'(m_cnt));
    check_eq("end_err", 32'(err), 32'(m_err));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
